// File: rtl/mos_lvl_pkg.sv
// Shared types for the MOS level monitor: four-valued level code, the
// change record carried through the output buffer, and the 4-state classifier.
package mos_lvl_pkg;

    typedef enum logic [1:0] {
        LV0 = 2'b00,
        LV1 = 2'b01,
        LVZ = 2'b10,
        LVX = 2'b11
    } lvl_t;

    typedef struct packed {
        lvl_t zn_lvl;
        lvl_t zp_lvl;
        logic zn_chg;
        logic zp_chg;
    } lvl_rec_t;

    // Case equality keeps Z and X distinguishable from driven levels.
    function automatic lvl_t classify(logic s);
        if (s === 1'b0)      return LV0;
        else if (s === 1'b1) return LV1;
        else if (s === 1'bz) return LVZ;
        else                 return LVX;
    endfunction

endpackage

// File: rtl/lvl_glitch_filter.sv
// Per-channel glitch filter: a level is accepted once FILT_LEN consecutive
// enabled samples agree and it differs from the currently accepted level.
module lvl_glitch_filter
    import mos_lvl_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic c,
    input  logic rst,
    input  logic en,
    input  lvl_t sample,
    output lvl_t acc,
    output logic evt
);

    localparam logic [3:0] RUN_FULL = 4'(FILT_LEN);

    lvl_t       cand_q, cand_d;
    lvl_t       acc_q, acc_d;
    logic [3:0] run_q, run_d;
    logic       evt_d;

    // evt is combinational so the record forms on the same edge acc updates;
    // on acceptance cand_d always equals the current sample.
    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        acc_d  = acc_q;
        evt_d  = 1'b0;
        if (en) begin
            if (sample == cand_q) begin
                if (run_q != RUN_FULL) run_d = run_q + 4'd1;
            end else begin
                cand_d = sample;
                run_d  = 4'd1;
            end
            if ((run_d == RUN_FULL) && (cand_d != acc_q)) begin
                acc_d = cand_d;
                evt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            cand_q <= LVX;
            acc_q  <= LVX;
            run_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            acc_q  <= acc_d;
            run_q  <= run_d;
        end
    end

    assign acc = acc_q;
    assign evt = evt_d;

endmodule

// File: rtl/mos_level_monitor.sv
// Observer for the MOS switch cell outputs: filtered level changes become
// records in a one-entry valid/ready buffer, plus zn history and statistics.
module mos_level_monitor
    import mos_lvl_pkg::*;
#(
    parameter int FILT_LEN   = 3,
    parameter int HIST_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    c,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    zn,
    input  logic                    zp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_zn_lvl,
    output logic [1:0]              out_zp_lvl,
    output logic                    out_zn_chg,
    output logic                    out_zp_chg,
    output logic [2*HIST_DEPTH-1:0] hist,
    output logic [CNT_W-1:0]        trans_cnt,
    output logic                    overflow,
    output logic                    conflict
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    lvl_t smp_zn, smp_zp, acc_zn, acc_zp, new_zn, new_zp;
    logic evt_zn, evt_zp, any_evt, pop;

    lvl_rec_t       rec_q, rec_d, rec_new;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic           conf_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_sum;

    assign smp_zn = classify(zn);
    assign smp_zp = classify(zp);

    lvl_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_zn (
        .c(c), .rst(rst), .en(en), .sample(smp_zn), .acc(acc_zn), .evt(evt_zn)
    );

    lvl_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_zp (
        .c(c), .rst(rst), .en(en), .sample(smp_zp), .acc(acc_zp), .evt(evt_zp)
    );

    // Records carry the post-edge accepted levels of both channels.
    assign new_zn  = evt_zn ? smp_zn : acc_zn;
    assign new_zp  = evt_zp ? smp_zp : acc_zp;
    assign rec_new = '{zn_lvl: new_zn, zp_lvl: new_zp, zn_chg: evt_zn, zp_chg: evt_zp};
    assign any_evt = evt_zn | evt_zp;
    assign pop     = valid_q & out_ready;

    always_comb begin
        rec_d   = rec_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (any_evt) begin
            if (!valid_q || pop) begin
                rec_d   = rec_new;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, evt_zn} + {{CNT_W{1'b0}}, evt_zp};
    assign cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

    always_ff @(posedge c) begin
        if (rst) begin
            rec_q   <= '{zn_lvl: LVX, zp_lvl: LVX, zn_chg: 1'b0, zp_chg: 1'b0};
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            conf_q  <= 1'b1;
        end else begin
            rec_q   <= rec_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            conf_q  <= (acc_zn != LVZ) && (acc_zp != LVZ);
        end
    end

    // History shift register; entry 0 is newest.
    genvar gi;
    generate
        for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            lvl_t ent_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge c) begin
                    if (rst)         ent_q <= LVX;
                    else if (evt_zn) ent_q <= new_zn;
                end
            end else begin : g_tail
                always_ff @(posedge c) begin
                    if (rst)         ent_q <= LVX;
                    else if (evt_zn) ent_q <= g_hist[gi-1].ent_q;
                end
            end
            assign hist[2*gi +: 2] = ent_q;
        end
    endgenerate

    assign out_valid  = valid_q;
    assign out_zn_lvl = rec_q.zn_lvl;
    assign out_zp_lvl = rec_q.zp_lvl;
    assign out_zn_chg = rec_q.zn_chg;
    assign out_zp_chg = rec_q.zp_chg;
    assign trans_cnt  = cnt_q;
    assign overflow   = ovf_q;
    assign conflict   = conf_q;

endmodule
